// File: rtl/par_deserializer.sv
// par_deserializer_pkg / par_deserializer
// Purpose : gathers LANES complex samples per input beat into a full frame of N
//           samples, in natural or bit-reversed order (BITREV), and presents the
//           frame on a registered output with a valid/ready handshake.
// Ports   : clk, reset (async, active-high), enable (global advance),
//           flush (drops a partial frame), in_valid/in_ready/data_in (beat
//           input), data_deserialized/out_valid/out_ready (frame output).
// Latency : one edge from the final beat to out_valid. Frames stream back to
//           back with no bubble. If the output is still held when the next
//           frame completes, in_ready drops until the consumer takes it.

package par_deserializer_pkg;

  localparam int SAMPLE_W = 16;

  typedef struct packed {
    logic signed [SAMPLE_W-1:0] r;
    logic signed [SAMPLE_W-1:0] i;
  } complex_product_t;

endpackage

module par_deserializer
  import par_deserializer_pkg::*;
#(
  parameter int N      = 8,
  parameter int LANES  = 2,
  parameter int BITREV = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  complex_product_t [LANES-1:0] data_in,
  output complex_product_t [N-1:0]     data_deserialized,
  output logic                       out_valid,
  input  logic                       out_ready
);

  localparam int BEATS = N / LANES;
  localparam int IW    = $clog2(N);
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

  typedef enum logic {
    FILL  = 1'b0,
    STALL = 1'b1
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [CW-1:0]           cnt;
  complex_product_t [N-1:0] fill_buf;
  complex_product_t [N-1:0] frame_nxt;

  logic accept;
  logic last_beat;
  logic stall_xfer;
  logic direct_xfer;

  // Fill-buffer slot for lane `lane` of beat `beat`.
  function automatic logic [IW-1:0] fill_pos(input logic [CW-1:0] beat, input int lane);
    logic [IW-1:0] nat;
    logic [IW-1:0] rev;
    nat = IW'(int'(beat) * LANES + lane);
    for (int b = 0; b < IW; b++) begin
      rev[b] = nat[IW-1-b];
    end
    return (BITREV != 0) ? rev : nat;
  endfunction

  assign accept    = in_valid && in_ready && !flush;
  assign last_beat = accept && (cnt == LAST_BEAT);

  // A frame parked in the fill buffer goes out as soon as the consumer frees the
  // output register. A flush on the same edge wins and throws the frame away.
  assign stall_xfer  = (state == STALL) && out_ready && !flush;
  // The final beat bypasses the fill buffer straight into the output register
  // when that register is free now or is being freed on this edge.
  assign direct_xfer = last_beat && (!out_valid || out_ready);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FILL;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = FILL;
    end else begin
      case (state)
        FILL:    if (last_beat && out_valid && !out_ready) state_nxt = STALL;
        STALL:   if (out_ready) state_nxt = FILL;
        default: state_nxt = FILL;
      endcase
    end
  end

  // Reset gates in_ready directly so it is low while reset is held, not just
  // after the first edge.
  always_comb begin
    in_ready = enable && (state == FILL) && !reset;
  end

  // ---------------------------------------------------------------- datapath
  // Fill buffer with the current beat merged in. This is the complete frame
  // when the final beat is being accepted.
  always_comb begin
    frame_nxt = fill_buf;
    for (int k = 0; k < LANES; k++) begin
      frame_nxt[fill_pos(cnt, k)] = data_in[k];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt               <= '0;
      fill_buf          <= '0;
      data_deserialized <= '0;
      out_valid         <= 1'b0;
    end else begin
      if (flush) begin
        cnt <= '0;
      end else if (accept) begin
        cnt <= last_beat ? '0 : cnt + 1'b1;
      end

      if (accept) begin
        fill_buf <= frame_nxt;
      end

      if (stall_xfer) begin
        data_deserialized <= fill_buf;
        out_valid         <= 1'b1;
      end else if (direct_xfer) begin
        data_deserialized <= frame_nxt;
        out_valid         <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_par_deserializer.sv
// tb_par_deserializer
// Purpose : drives two deserializers (natural and bit-reversed order) with the
//           same beats and scores each retired frame against a reference queue.
// Ports   : none. Clock is generated locally; both DUTs share all inputs.

module tb_par_deserializer;
  import par_deserializer_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic enable;
  logic flush;
  logic in_valid;
  logic out_ready;
  complex_product_t [1:0] data_in;
  complex_product_t [7:0] d0;
  complex_product_t [7:0] d1;
  logic ir0, ir1, ov0, ov1;

  always #5 clk = ~clk;

  par_deserializer #(.N(8), .LANES(2), .BITREV(0)) u_nat (
    .clk(clk), .reset(reset), .enable(enable), .flush(flush),
    .in_valid(in_valid), .in_ready(ir0), .data_in(data_in),
    .data_deserialized(d0), .out_valid(ov0), .out_ready(out_ready)
  );

  par_deserializer #(.N(8), .LANES(2), .BITREV(1)) u_rev (
    .clk(clk), .reset(reset), .enable(enable), .flush(flush),
    .in_valid(in_valid), .in_ready(ir1), .data_in(data_in),
    .data_deserialized(d1), .out_valid(ov1), .out_ready(out_ready)
  );

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  int stalls = 0;

  logic [255:0] exp_q[$];
  int           pops[$];
  logic [255:0] cur = '0;
  int           cur_cnt = 0;
  logic         hold = 1'b0;
  logic [255:0] held;
  logic [255:0] mon_e;
  bit           first_rev = 1'b1;
  int           rev_tbl[8] = '{0, 4, 2, 6, 1, 5, 3, 7};

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Position p of a bit-reversed frame holds natural sample bitrev(p).
  function automatic logic [255:0] to_rev(input logic [255:0] nat);
    logic [255:0] r;
    logic [2:0]   pp;
    logic [2:0]   rp;
    r = '0;
    for (int p = 0; p < 8; p++) begin
      pp = 3'(p);
      rp = {pp[0], pp[1], pp[2]};
      r[32*p +: 32] = nat[32*int'(rp) +: 32];
    end
    return r;
  endfunction

  always @(posedge clk) cyc++;

  // Present one beat, wait (bounded) for acceptance and record it in the model.
  task automatic send_beat(input logic [15:0] r0, input logic [15:0] i0,
                           input logic [15:0] r1, input logic [15:0] i1);
    int w;
    bit done;
    w = 0;
    done = 1'b0;
    in_valid   = 1'b1;
    data_in[0] = {r0, i0};
    data_in[1] = {r1, i1};
    while (!done) begin
      @(negedge clk);
      if (ir0 && !flush) begin
        cur[64*cur_cnt +: 32]      = {r0, i0};
        cur[64*cur_cnt + 32 +: 32] = {r1, i1};
        cur_cnt++;
        if (cur_cnt == 4) begin
          exp_q.push_back(cur);
          cur_cnt = 0;
        end
        done = 1'b1;
      end else begin
        stalls++;
        w++;
        if (w > 50) begin
          check("beat_timeout", 256'(ir0), 256'(1));
          done = 1'b1;
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  // Output monitor: compares on every retirement and checks that a frame held
  // under backpressure does not move.
  always @(negedge clk) begin
    if (reset) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        check("hold_vld", 256'(ov0), 256'(1));
        check("hold_dat", d0, held);
      end
      if (ov0 && out_ready) begin
        check("sb_nonempty", 256'(exp_q.size() != 0), 256'(1));
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check("frame_nat", d0, mon_e);
          check("frame_rev", d1, to_rev(mon_e));
          check("vld_match", 256'(ov1), 256'(1));
          if (first_rev) begin
            logic [255:0] rv;
            logic [255:0] ev;
            rv = '0;
            ev = '0;
            for (int p = 0; p < 8; p++) begin
              rv[16*p +: 16] = d1[p].r;
              ev[16*p +: 16] = 16'(rev_tbl[p]);
            end
            check("rev_table", rv, ev);
            first_rev = 1'b0;
          end
          pops.push_back(cyc);
        end
      end
      hold = ov0 && !out_ready;
      held = d0;
    end
  end

  initial begin
    reset     = 1'b1;
    enable    = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    data_in   = '0;

    #1;
    check("rst_vld", 256'(ov0), 256'(0));
    check("rst_rdy", 256'(ir0), 256'(0));
    check("rst_dat", d0, 256'(0));

    @(posedge clk);
    #1;
    reset = 1'b0;

    // Natural / bit-reversed order, single frame with imag 0.
    for (int i = 0; i < 4; i++) send_beat(16'(2*i), 16'd0, 16'(2*i+1), 16'd0);
    in_valid = 1'b0;
    @(negedge clk);
    check("lat_vld", 256'(ov0), 256'(1));
    @(negedge clk);
    check("pulse_end", 256'(ov0), 256'(0));
    @(posedge clk);
    #1;

    // Back-to-back frames, consumer always ready.
    pops.delete();
    stalls = 0;
    for (int i = 0; i < 12; i++)
      send_beat(16'(16+2*i), 16'($urandom), 16'(17+2*i), 16'($urandom));
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("b2b_stalls", 256'(stalls), 256'(0));
    check("b2b_pulses", 256'(pops.size()), 256'(3));
    if (pops.size() == 3) begin
      check("b2b_gap1", 256'(pops[1] - pops[0]), 256'(4));
      check("b2b_gap2", 256'(pops[2] - pops[1]), 256'(4));
    end

    // Partial frame, enable low, then flush with a junk beat presented.
    send_beat(16'd50, 16'd1, 16'd51, 16'd1);
    send_beat(16'd52, 16'd1, 16'd53, 16'd1);
    enable     = 1'b0;
    in_valid   = 1'b1;
    data_in[0] = {16'd900, 16'd9};
    data_in[1] = {16'd901, 16'd9};
    @(negedge clk);
    check("en_lo_rdy", 256'(ir0), 256'(0));
    @(posedge clk);
    #1;
    enable = 1'b1;
    flush  = 1'b1;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    cur_cnt  = 0;
    for (int i = 0; i < 4; i++) send_beat(16'(100+2*i), 16'd7, 16'(101+2*i), 16'd7);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Backpressure across two frames, then a single out_ready pulse.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_beat(16'(200+2*i), 16'($urandom), 16'(201+2*i), 16'($urandom));
    for (int i = 0; i < 4; i++) send_beat(16'(300+2*i), 16'($urandom), 16'(301+2*i), 16'($urandom));
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_rdy_lo", 256'(ir0), 256'(0));
    check("bp_vld", 256'(ov0), 256'(1));
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("bp_rdy_back", 256'(ir0), 256'(1));
    check("bp_f2_vld", 256'(ov0), 256'(1));
    check("bp_f2_dat", d0, (exp_q.size() != 0) ? exp_q[0] : 256'(0));
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Reset between edges while a frame is held and another is half built.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_beat(16'(400+2*i), 16'd3, 16'(401+2*i), 16'd3);
    for (int i = 0; i < 3; i++) send_beat(16'(500+2*i), 16'd4, 16'(501+2*i), 16'd4);
    in_valid = 1'b0;
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("mrst_vld", 256'(ov0), 256'(0));
    check("mrst_rdy", 256'(ir0), 256'(0));
    check("mrst_dat", d0, 256'(0));
    check("mrst_dat_rev", d1, 256'(0));
    exp_q.delete();
    cur_cnt = 0;
    @(posedge clk);
    #1;
    reset     = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) send_beat(16'(600+2*i), 16'd5, 16'(601+2*i), 16'd5);
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    check("sb_drain", 256'(exp_q.size()), 256'(0));

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/par_deserializer.md
PAR_DESERIALIZER -- requirements
Module: par_deserializer

Interface
REQ-001 SHALL have parameter N, default 8: frame length in complex samples; power of two, at least 2.
REQ-002 SHALL have parameter LANES, default 2: samples accepted per beat; power of two, at most N.
REQ-003 SHALL have parameter BITREV, default 0: 0 = natural output order, 1 = bit-reversed output order (log2(N)-bit index reversal).
REQ-004 SHALL have ports (name, direction, width, meaning):
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high.
- enable  in  1  global advance; when 0 no beat is accepted and no state changes except output retirement.
- flush  in  1  synchronous abort of the partially filled frame.
- in_valid  in  1  data_in holds a valid beat.
- in_ready  out  1  block can accept a beat this cycle.
- data_in  in  LANES x complex_product_t  lane k is sample k of the beat.
- data_deserialized  out  N x complex_product_t  assembled frame.
- out_valid  out  1  data_deserialized holds a complete frame.
- out_ready  in  1  consumer takes the frame this cycle.

Function
REQ-005 SHALL accept a beat on a rising edge when in_valid && in_ready && !flush.
REQ-006 SHALL drive in_ready = enable && (state == FILL).
REQ-007 SHALL keep a beat counter 0..N/LANES-1 and a fill buffer of N samples.
- Lane k of beat b has natural index j = b*LANES+k.
- It is written to fill position j when BITREV=0, and to bitrev(j) when BITREV=1.
REQ-008 SHALL implement states FILL and STALL.
- FILL -> STALL when the final beat (counter = N/LANES-1) is accepted while out_valid=1 and out_ready=0.
- STALL -> FILL on the edge where out_ready=1; the fill buffer transfers to the output register on that edge.
REQ-009 SHALL, when the final beat is accepted with out_valid=0 or out_ready=1, do all of the following on that edge:
- copy the completed frame, including the final beat, to the output register;
- set out_valid=1;
- wrap the counter to 0;
- remain in FILL. This gives one cycle of latency from final beat to out_valid and no bubble between frames.
REQ-010 SHALL clear out_valid on an edge where out_valid && out_ready, unless a new frame is transferred on that same edge.
REQ-011 SHALL hold data_deserialized and out_valid stable while out_valid=1 and out_ready=0.
REQ-012 SHALL, on flush=1 at a rising edge:
- zero the counter and force state FILL, discarding any STALL frame;
- discard any beat presented that cycle;
- leave the output register and out_valid unaffected.
REQ-013 SHALL, when enable=0, still honour out_ready retirement and a STALL transfer, but accept no input beats.
REQ-014 SHALL pass samples through bit-exact, with no arithmetic or width change.

Reset
REQ-015 SHALL, while reset=1 and independent of clk, force counter=0, state=FILL, out_valid=0, every data_deserialized element to zero, and in_ready=0.
REQ-016 SHALL resume accepting beats on the first rising edge after reset deasserts with enable=1; a frame interrupted by reset is lost.

Verification
REQ-017 Natural order: N=8, LANES=2, BITREV=0, out_ready=1; beats i=0..3 with lane0.r=2i, lane1.r=2i+1, imag 0 -> one cycle after beat 3, out_valid=1 for one cycle and data_deserialized[j].r=j for j=0..7.
REQ-018 Bit-reversed order: same stimulus with BITREV=1 -> data_deserialized[].r = {0,4,2,6,1,5,3,7} for positions 0..7.
REQ-019 Back-to-back frames: 12 consecutive beats with out_ready=1 -> three out_valid pulses, 4 cycles apart; in_ready never drops.
REQ-020 Backpressure: out_ready=0 across two full frames ->
- frame 1 stays held on the output;
- in_ready=0 after frame 2's final beat;
- one out_ready pulse -> frame 2 appears on the next cycle, in_ready returns to 1, frame 1 data is never corrupted.
REQ-021 Flush mid-frame: 2 beats, then flush, then 4 new beats with r values 100..107 -> the output frame contains only 100..107.
REQ-022 Reset mid-frame: assert reset after 3 beats, between clock edges -> out_valid=0 and outputs zero immediately; the next 4 beats produce a correct frame.
